// File: rtl/adex_pkg.sv
// Shared constants, state encoding and nibble selection for the AdEx nibble parameter-load protocol.
package adex_pkg;

    localparam int NUM_PARAMS = 8;
    localparam logic [3:0] FOOTER_NIB = 4'hF;

    localparam int P_DELTAT = 0;
    localparam int P_TAUW   = 1;
    localparam int P_A      = 2;
    localparam int P_B      = 3;
    localparam int P_VRESET = 4;
    localparam int P_VT     = 5;
    localparam int P_IBIAS  = 6;
    localparam int P_C      = 7;

    localparam logic [63:0] DEFAULT_PARAMS_FLAT = {8'd200, 8'd143, 8'd78, 8'd63,
                                                   8'd168, 8'd130, 8'd228, 8'd130};

    // Header is strobe 0, two nibbles per byte follow, footer is the final strobe.
    localparam logic [4:0] LAST_STROBE = 5'(2 * NUM_PARAMS + 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_REARM  = 3'd1,
        TX_SETUP  = 3'd2,
        TX_GAP    = 3'd3,
        TX_STROBE = 3'd4,
        TX_HOLD   = 3'd5
    } tx_state_e;

    localparam logic [2:0] ST_IDLE   = TX_IDLE;
    localparam logic [2:0] ST_REARM  = TX_REARM;
    localparam logic [2:0] ST_SETUP  = TX_SETUP;
    localparam logic [2:0] ST_GAP    = TX_GAP;
    localparam logic [2:0] ST_STROBE = TX_STROBE;
    localparam logic [2:0] ST_HOLD   = TX_HOLD;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Nibble carried by strobe s: header 0, then high/low nibble of each byte, then footer.
    function automatic logic [3:0] frame_nibble(input logic [4:0] s, input logic [63:0] snap);
        logic [2:0] idx_v;
        logic [7:0] byte_v;
        idx_v  = 3'((s - 5'd1) >> 1);
        byte_v = snap[{idx_v, 3'b000} +: 8];
        if (s == 5'd0) begin
            return 4'h0;
        end else if (s >= LAST_STROBE) begin
            return FOOTER_NIB;
        end else if (s[0]) begin
            return byte_v[7:4];
        end else begin
            return byte_v[3:0];
        end
    endfunction

endpackage

// File: rtl/adex_strobe_timer.sv
// Load/count-down phase counter; term marks the last cycle of the loaded phase.
module adex_strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         term
);

    logic [W-1:0] cnt_r;

    // Phase counter: load on phase entry, count down to zero and stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign term = (cnt_r == W'(1));

endmodule

// File: rtl/adex_param_stream_tx.sv
// Host-side AdEx nibble parameter-load transmitter (protocol master).
// Optional ADEX_TX_AUTO_RELEASE_EN: leave HOLD by itself after HOLD_CYCLES idle cycles.
module adex_param_stream_tx
    import adex_pkg::*;
#(
    parameter int STROBE_HIGH = 2,
    parameter int STROBE_GAP  = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] params_flat,
    input  logic        release_req,
    input  logic        abort,
    output logic        load_mode_o,
    output logic        load_enable_o,
    output logic [3:0]  nibble_o,
    output logic        busy,
    output logic        done,
    output logic        hold_o
);

`ifdef ADEX_TX_AUTO_RELEASE_EN
    localparam bit AUTO_RELEASE = 1'b1;
`else
    localparam bit AUTO_RELEASE = 1'b0;
`endif

    // Without auto-release the hold phase needs no count, so the counter stays narrow.
    localparam int HOLD_SPAN = AUTO_RELEASE ? HOLD_CYCLES : 0;
    localparam int CNT_MAX   = max_int(max_int(STROBE_HIGH, STROBE_GAP), HOLD_SPAN);
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOAD_HIGH = CW'(STROBE_HIGH);
    localparam logic [CW-1:0] LOAD_GAP  = CW'(STROBE_GAP);
    localparam logic [CW-1:0] LOAD_HOLD = CW'(HOLD_SPAN);

    logic [2:0]    state_r;
    logic [4:0]    s_r;
    logic          last_r;
    logic [63:0]   snap_r;

    logic [2:0]    nstate_s;
    logic [4:0]    ns_s;
    logic          nlast_s;
    logic [63:0]   nsnap_s;
    logic          tload_s;
    logic [CW-1:0] tval_s;
    logic          tterm_s;

    logic          load_mode_s;
    logic          load_enable_s;
    logic [3:0]    nibble_s;
    logic          busy_s;
    logic          done_s;
    logic          hold_s;

    adex_strobe_timer #(
        .W(CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tload_s),
        .load_val (tval_s),
        .term     (tterm_s)
    );

    // Next-state logic; abort overrides everything, start beats release_req in HOLD.
    always_comb begin
        nstate_s = state_r;
        ns_s     = s_r;
        nlast_s  = last_r;
        nsnap_s  = snap_r;
        tload_s  = 1'b0;
        tval_s   = {CW{1'b0}};
        if (abort) begin
            nstate_s = ST_IDLE;
            ns_s     = 5'd0;
            nlast_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nstate_s = ST_SETUP;
                        nsnap_s  = params_flat;
                        ns_s     = 5'd0;
                        nlast_s  = 1'b0;
                        tload_s  = 1'b1;
                        tval_s   = LOAD_GAP;
                    end else begin
                        nstate_s = ST_IDLE;
                    end
                end
                ST_REARM: begin
                    if (tterm_s) begin
                        nstate_s = ST_SETUP;
                        tload_s  = 1'b1;
                        tval_s   = LOAD_GAP;
                    end else begin
                        nstate_s = ST_REARM;
                    end
                end
                ST_SETUP: begin
                    if (tterm_s) begin
                        nstate_s = ST_STROBE;
                        tload_s  = 1'b1;
                        tval_s   = LOAD_HIGH;
                    end else begin
                        nstate_s = ST_SETUP;
                    end
                end
                ST_STROBE: begin
                    if (tterm_s) begin
                        nstate_s = ST_GAP;
                        tload_s  = 1'b1;
                        tval_s   = LOAD_GAP;
                        if (s_r >= LAST_STROBE) begin
                            nlast_s = 1'b1;
                        end else begin
                            ns_s = s_r + 5'd1;
                        end
                    end else begin
                        nstate_s = ST_STROBE;
                    end
                end
                ST_GAP: begin
                    if (tterm_s && last_r) begin
                        nstate_s = ST_HOLD;
                        tload_s  = 1'b1;
                        tval_s   = LOAD_HOLD;
                    end else if (tterm_s) begin
                        nstate_s = ST_STROBE;
                        tload_s  = 1'b1;
                        tval_s   = LOAD_HIGH;
                    end else begin
                        nstate_s = ST_GAP;
                    end
                end
                ST_HOLD: begin
                    if (start) begin
                        nstate_s = ST_REARM;
                        nsnap_s  = params_flat;
                        ns_s     = 5'd0;
                        nlast_s  = 1'b0;
                        tload_s  = 1'b1;
                        tval_s   = LOAD_GAP;
                    end else if (release_req) begin
                        nstate_s = ST_IDLE;
`ifdef ADEX_TX_AUTO_RELEASE_EN
                    end else if (tterm_s) begin
                        nstate_s = ST_IDLE;
`endif
                    end else begin
                        nstate_s = ST_HOLD;
                    end
                end
                default: begin
                    nstate_s = ST_IDLE;
                    ns_s     = 5'd0;
                    nlast_s  = 1'b0;
                end
            endcase
        end
    end

    // Output decode from the next state so every pin comes straight from a flop.
    always_comb begin
        load_mode_s   = 1'b0;
        load_enable_s = 1'b0;
        nibble_s      = 4'h0;
        busy_s        = 1'b0;
        hold_s        = 1'b0;
        case (nstate_s)
            ST_SETUP, ST_GAP: begin
                load_mode_s = 1'b1;
                busy_s      = 1'b1;
                nibble_s    = frame_nibble(ns_s, nsnap_s);
            end
            ST_STROBE: begin
                load_mode_s   = 1'b1;
                load_enable_s = 1'b1;
                busy_s        = 1'b1;
                nibble_s      = frame_nibble(ns_s, nsnap_s);
            end
            ST_HOLD: begin
                load_mode_s = 1'b1;
                hold_s      = 1'b1;
            end
            default: begin
                load_mode_s = 1'b0;
                hold_s      = 1'b0;
            end
        endcase
        if ((nstate_s == ST_HOLD) && (state_r != ST_HOLD)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // State, frame snapshot and registered protocol outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            s_r           <= 5'd0;
            last_r        <= 1'b0;
            snap_r        <= 64'd0;
            load_mode_o   <= 1'b0;
            load_enable_o <= 1'b0;
            nibble_o      <= 4'h0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hold_o        <= 1'b0;
        end else begin
            state_r       <= nstate_s;
            s_r           <= ns_s;
            last_r        <= nlast_s;
            snap_r        <= nsnap_s;
            load_mode_o   <= load_mode_s;
            load_enable_o <= load_enable_s;
            nibble_o      <= nibble_s;
            busy          <= busy_s;
            done          <= done_s;
            hold_o        <= hold_s;
        end
    end

endmodule

// File: tb/tb_adex_param_stream_tx.sv
// Directed bench for adex_param_stream_tx: strobe scoreboard plus a simple receiver model.
module tb_adex_param_stream_tx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] params_flat;
    logic        release_req;
    logic        abort;
    logic        load_mode_o;
    logic        load_enable_o;
    logic [3:0]  nibble_o;
    logic        busy;
    logic        done;
    logic        hold_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [3:0] nib;
    } exp_t;
    exp_t exp_q[$];

    logic        rx_ready;
    logic [63:0] rx_params;

    adex_param_stream_tx #(
        .STROBE_HIGH(2),
        .STROBE_GAP (4),
        .HOLD_CYCLES(10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .params_flat   (params_flat),
        .release_req   (release_req),
        .abort         (abort),
        .load_mode_o   (load_mode_o),
        .load_enable_o (load_enable_o),
        .nibble_o      (nibble_o),
        .busy          (busy),
        .done          (done),
        .hold_o        (hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected strobes s=0..n-1 of a frame whose start is sampled at cycle c.
    task automatic push_frame(input logic [63:0] p, input int c, input int n);
        exp_t e;
        logic [7:0] b;
        for (int s = 0; s < n; s++) begin
            e.cyc = c + 5 + 6 * s;
            if (s == 0) begin
                e.nib = 4'h0;
            end else if (s == 17) begin
                e.nib = 4'hF;
            end else begin
                b = p[8 * ((s - 1) / 2) +: 8];
                e.nib = (s % 2 == 1) ? b[7:4] : b[3:0];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Strobe monitor and receiver model, sampled on the falling edge.
    initial begin
        logic le_prev;
        int   le_len;
        int   rx_cnt;
        int   k;
        logic [63:0] rx_buf;
        exp_t e;
        le_prev = 1'b0;
        le_len = 0;
        rx_cnt = 0;
        rx_buf = 64'd0;
        rx_ready = 1'b0;
        rx_params = 64'd0;
        forever begin
            @(negedge clk);
            if (load_enable_o && !le_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {32'd0, cyc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_nibble", nibble_o, e.nib);
                end
                le_len = 1;
                if (load_mode_o) begin
                    if (rx_cnt >= 1 && rx_cnt <= 16) begin
                        k = (rx_cnt - 1) / 2;
                        if (rx_cnt % 2 == 1) rx_buf[8 * k + 4 +: 4] = nibble_o;
                        else rx_buf[8 * k +: 4] = nibble_o;
                    end else if (rx_cnt == 17 && nibble_o == 4'hF) begin
                        rx_ready = 1'b1;
                        rx_params = rx_buf;
                    end
                    rx_cnt++;
                end
            end else if (load_enable_o) begin
                le_len++;
            end else if (le_prev && load_mode_o) begin
                chk("strobe_width", le_len, 2);
            end
            if (!load_mode_o) begin
                rx_cnt = 0;
                rx_ready = 1'b0;
            end
            le_prev = load_enable_o;
        end
    end

    initial begin
        int c0;
        int c1;
        int d;
        logic seen;
        logic [63:0] p1;
        logic [63:0] p2;
        logic [63:0] p3;
        logic [63:0] p4;
        p1 = 64'hC88F_4E3F_A882_E482;
        p2 = 64'h5A5A_F00F_1234_8765;
        p3 = 64'hFFEE_DDCC_BBAA_9988;
        p4 = 64'h0123_4567_89AB_CDEF;

        rst_n = 1'b0;
        start = 1'b0;
        params_flat = 64'd0;
        release_req = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load_mode", load_mode_o, 1'b0);
        chk("rst_load_enable", load_enable_o, 1'b0);
        chk("rst_nibble", nibble_o, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hold", hold_o, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: reference vector; params change right after the snapshot.
        params_flat = p1;
        start = 1'b1;
        c0 = cyc;
        push_frame(p1, c0, 18);
        @(negedge clk);
        start = 1'b0;
        params_flat = ~p1;
        chk("f1_load_mode_c1", load_mode_o, 1'b1);
        chk("f1_busy_c1", busy, 1'b1);
        wait_cyc(c0 + 112);
        chk("f1_busy_c112", busy, 1'b1);
        chk("f1_done_c112", done, 1'b0);
        wait_cyc(c0 + 113);
        chk("f1_done_c113", done, 1'b1);
        chk("f1_hold_c113", hold_o, 1'b1);
        chk("f1_busy_c113", busy, 1'b0);
        chk("f1_mode_c113", load_mode_o, 1'b1);
        chk("f1_nibble_hold", nibble_o, 4'h0);
        wait_cyc(c0 + 114);
        chk("f1_done_pulse", done, 1'b0);
        chk("f1_queue_empty", exp_q.size(), 0);
        chk("f1_rx_ready", rx_ready, 1'b1);
        chk("f1_rx_params", rx_params, p1);

        // Release from HOLD.
        release_req = 1'b1;
        @(negedge clk);
        release_req = 1'b0;
        chk("rel_load_mode", load_mode_o, 1'b0);
        chk("rel_hold", hold_o, 1'b0);
        @(negedge clk);
        chk("rel_rx_ready", rx_ready, 1'b0);

        // Frame 2 with an ignored mid-frame start, then re-arm from HOLD.
        params_flat = p2;
        start = 1'b1;
        c0 = cyc;
        push_frame(p2, c0, 18);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 30);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 113);
        chk("f2_done", done, 1'b1);
        wait_cyc(c0 + 114);
        chk("f2_rx_params", rx_params, p2);
        params_flat = p3;
        start = 1'b1;
        release_req = 1'b1;
        c1 = cyc;
        push_frame(p3, c1 + 4, 18);
        @(negedge clk);
        start = 1'b0;
        release_req = 1'b0;
        chk("rearm_mode_c1", load_mode_o, 1'b0);
        chk("rearm_hold_c1", hold_o, 1'b0);
        wait_cyc(c1 + 4);
        chk("rearm_mode_c4", load_mode_o, 1'b0);
        wait_cyc(c1 + 5);
        chk("rearm_mode_c5", load_mode_o, 1'b1);
        chk("rearm_busy_c5", busy, 1'b1);
        d = c1 + 4 + 113;
        wait_cyc(d);
        chk("f3_done", done, 1'b1);
        wait_cyc(d + 1);
        chk("f3_rx_params", rx_params, p3);
        chk("f3_queue_empty", exp_q.size(), 0);
`ifdef ADEX_TX_AUTO_RELEASE_EN
        wait_cyc(d + 9);
        chk("auto_mode_d9", load_mode_o, 1'b1);
        wait_cyc(d + 10);
        chk("auto_mode_d10", load_mode_o, 1'b0);
        chk("auto_hold_d10", hold_o, 1'b0);
`else
        wait_cyc(d + 120);
        chk("hold_mode_d120", load_mode_o, 1'b1);
        chk("hold_hold_d120", hold_o, 1'b1);
`endif
        release_req = 1'b1;
        @(negedge clk);
        release_req = 1'b0;
        chk("idle_after_hold", load_mode_o, 1'b0);
        @(negedge clk);

        // Frame 4: abort during the high phase of strobe 9.
        params_flat = p4;
        start = 1'b1;
        c0 = cyc;
        push_frame(p4, c0, 10);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 59);
        chk("abort_pre_le", load_enable_o, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_mode", load_mode_o, 1'b0);
        chk("abort_le", load_enable_o, 1'b0);
        chk("abort_nibble", nibble_o, 4'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_hold", hold_o, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            seen = seen | done | load_mode_o | busy | load_enable_o;
        end
        chk("abort_quiet", seen, 1'b0);
        chk("abort_queue_empty", exp_q.size(), 0);
        chk("abort_rx_idle", rx_ready, 1'b0);

        // Frame 5: asynchronous reset between edges in the first GAP.
        params_flat = p4;
        start = 1'b1;
        c0 = cyc;
        push_frame(p4, c0, 1);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 8);
        chk("gap_nibble", nibble_o, 4'hE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mode", load_mode_o, 1'b0);
        chk("arst_nibble", nibble_o, 4'h0);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_queue_empty", exp_q.size(), 0);

        // Frame 6: normal frame after reset.
        params_flat = p2;
        start = 1'b1;
        c0 = cyc;
        push_frame(p2, c0, 18);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(c0 + 113);
        chk("f6_done", done, 1'b1);
        wait_cyc(c0 + 114);
        chk("f6_rx_params", rx_params, p2);
        chk("f6_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
